// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset PC, the fetch-queue entry
// layout and the encoding decode sees during a bubble.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count. The head is read straight
// from storage, so a word pushed in one cycle is visible the next.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Push/pop qualification; overflow and underflow are refused outright.
  always_comb begin
    do_push_s = push && !clear && (count_r != CW'(DEPTH));
    do_pop_s  = pop && !clear && (count_r != CW'(0));
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr_r <= AW'(0);
      wr_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a prefetch buffer: issues word fetches to a
// variable-latency memory and hands {ir, pc+4} to decode in program order.
module fetch_queue #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ir,
  output logic [XLEN-1:0] out_pc4
);

  import cpu_pkg::*;

  localparam logic [CW:0] DEPTH_LIM = DEPTH[CW:0];

  logic [XLEN-1:0]   fetch_pc_r, fetch_pc_nxt_s;
  logic [XLEN-1:0]   rsp_pc_r, rsp_pc_nxt_s;
  logic [CW-1:0]     inflight_r, inflight_nxt_s;
  logic [CW-1:0]     drop_r, drop_nxt_s;
  logic [CW-1:0]     count_s;
  logic [2*XLEN-1:0] head_s;
  logic              req_valid_s, accept_s, stale_s, live_s;
  logic              push_s, pop_s, head_valid_s;

  // Issue gate (room for every live fetch, bounded outstanding) and handshakes.
  always_comb begin
    head_valid_s = (count_s != CW'(0));
    req_valid_s  = !reset && !redirect_valid
                   && (({1'b0, count_s} + {1'b0, inflight_r}) < DEPTH_LIM)
                   && (({1'b0, inflight_r} + {1'b0, drop_r}) < DEPTH_LIM);
    accept_s     = req_valid_s && imem_req_ready;
    stale_s      = imem_rsp_valid && (drop_r != CW'(0));
    live_s       = imem_rsp_valid && (drop_r == CW'(0));
    push_s       = live_s && !redirect_valid;
    pop_s        = head_valid_s && out_ready && !redirect_valid;
  end

  // rsp_pc tracks the PC of the next live response, so no tag queue is needed.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    rsp_pc_nxt_s   = rsp_pc_r;
    inflight_nxt_s = inflight_r;
    drop_nxt_s     = drop_r;
    if (redirect_valid) begin
      fetch_pc_nxt_s = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_nxt_s   = {redirect_pc[XLEN-1:2], 2'b00};
      inflight_nxt_s = CW'(0);
      drop_nxt_s     = drop_r + inflight_r - CW'(imem_rsp_valid);
    end else begin
      fetch_pc_nxt_s = accept_s ? fetch_pc_r + XLEN'(32'd4) : fetch_pc_r;
      rsp_pc_nxt_s   = push_s ? rsp_pc_r + XLEN'(32'd4) : rsp_pc_r;
      inflight_nxt_s = inflight_r + CW'(accept_s) - CW'(live_s);
      drop_nxt_s     = drop_r - CW'(stale_s);
    end
  end

  // State registers; reset outranks redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      inflight_r <= CW'(0);
      drop_r     <= CW'(0);
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      rsp_pc_r   <= rsp_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_r     <= drop_nxt_s;
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push_s),
    .push_data ({imem_rsp_data, rsp_pc_r + XLEN'(32'd4)}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  // Bubbles present a NOP with a zero PC tag.
  assign out_valid      = head_valid_s;
  assign out_ir         = head_valid_s ? head_s[2*XLEN-1:XLEN] : XLEN'(NOP);
  assign out_pc4        = head_valid_s ? head_s[XLEN-1:0] : XLEN'(32'd0);
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle table for fill/stall/redirect plus
// hand sequences for slow-memory redirect, PC wrap and reset while full.
module tb_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir;
  logic [31:0] out_pc4;

  always #5 clock = ~clock;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc4(out_pc4)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int mem_lat = 1;
  logic [31:0] q_addr[$];
  int q_due[$];
  logic [31:0] exp_pc4 = 32'h4;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ordy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] epc4;
  } vec_t;
  vec_t tbl[19];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ~a ^ 32'h1357_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with this cycle's inputs applied; returns at next posedge+1.
  task automatic step();
    logic        acc;
    logic        rsp;
    logic [31:0] acc_addr;
    #3;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rsp      = imem_rsp_valid;
    if (out_valid && out_ready && !redirect_valid && !reset) begin
      check("pop_pc4", out_pc4, exp_pc4);
      check("pop_ir", out_ir, word_at(exp_pc4 - 32'd4));
      exp_pc4 = exp_pc4 + 32'd4;
      pops++;
    end
    if (reset) exp_pc4 = RESET_PC + 32'd4;
    else if (redirect_valid) exp_pc4 = {redirect_pc[31:2], 2'b00} + 32'd4;
    @(posedge clock);
    #1;
    if (reset) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (rsp) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (acc) begin
        q_addr.push_back(acc_addr);
        q_due.push_back(cyc + mem_lat);
      end
    end
    cyc++;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(q_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int  p0;
    bit  seen;

    // {rv, rpc, out_ready, exp req_valid, exp req_addr, exp out_valid, exp out_pc4}
    tbl[0]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
    tbl[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};
    tbl[14] = '{1'b1, 32'h102, 1'b1, 1'b0, 32'h28, 1'b1, 32'h20};
    tbl[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
    tbl[18] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};

    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_out_ir", out_ir, 32'h0);
    check("rst_out_pc4", out_pc4, 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    step();
    reset = 1'b0;

    // Fill, stall until full, drain, then redirect to 0x102 alongside a response and a pop.
    for (int i = 0; i < 19; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].ordy;
      #2;
      check($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].ereq));
      check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      if (tbl[i].eov) check($sformatf("tbl%0d_out_pc4", i), out_pc4, tbl[i].epc4);
      step();
    end
    redirect_valid = 1'b0;

    // Three fetches outstanding on 3-cycle memory, redirect as the first returns.
    mem_lat = 3;
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #2;
    check("slow_redir_req_valid", 32'(imem_req_valid), 32'd0);
    check("slow_redir_rsp_present", 32'(imem_rsp_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    p0 = pops;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #2;
      if (out_valid) seen = 1'b1;
      else step();
    end
    check("slow_redir_seen", 32'(seen), 32'd1);
    check("slow_redir_first_pc4", out_pc4, 32'h104);
    check("slow_redir_no_stale_pop", 32'(pops - p0), 32'd0);
    step();
    for (int k = 0; k < 6; k++) step();

    // PC wrap at the top of the address space.
    mem_lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #2;
    check("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_req_valid0", 32'(imem_req_valid), 32'd1);
    step();
    #2;
    check("wrap_req_addr1", imem_req_addr, 32'h0);
    step();
    #2;
    check("wrap_out_pc4", out_pc4, 32'h0);
    for (int k = 0; k < 5; k++) step();

    // Reset while the queue is full.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) step();
    #2;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_req_blocked", 32'(imem_req_valid), 32'd0);
    do_reset();
    #2;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    out_ready = 1'b1;
    p0 = pops;
    for (int k = 0; k < 6; k++) step();
    check("post_rst_pops", 32'(pops - p0), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
